// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the multi-channel SAR ADC reader.
// Pure declarations; no logic, no latency, no flow control.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        READ,
        DONE,
        ACQ
    } adc_state_e;

    // Wide enough to hold the largest down-count the FSM ever loads.
    function automatic int cnt_w(input int conv, input int acq, input int div);
        int m;
        m = conv;
        if (acq > m) m = acq;
        if (2 * div > m) m = 2 * div;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Edges from the start-accepting edge up to and including the VALID edge.
    function automatic int valid_latency(input int conv, input int div, input int w);
        return 1 + conv + 2 * div * w;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator: DATA_W pulses of 2*SCK_DIV cycles, low half first.
// Strobes are combinational from local flops; counters clear whenever en_i drops.
module adc_sck_gen #(
    parameter int DATA_W  = 16,
    parameter int SCK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic sample_o,
    output logic done_o
);
    localparam int PH_W  = (SCK_DIV < 2) ? 1 : $clog2(SCK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    logic [PH_W-1:0]  ph_q;
    logic [BIT_W-1:0] bit_q;
    logic             hi_q;
    logic             sck_q;
    logic             ph_end;

    assign ph_end   = (ph_q == PH_W'(SCK_DIV - 1));
    assign sample_o = en_i & ph_end & ~hi_q;
    assign done_o   = en_i & ph_end & hi_q & (bit_q == BIT_W'(DATA_W - 1));
    assign sck_o    = sck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q  <= '0;
            bit_q <= '0;
            hi_q  <= 1'b0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            ph_q  <= '0;
            bit_q <= '0;
            hi_q  <= 1'b0;
            sck_q <= 1'b0;
        end else if (ph_end) begin
            // SCK rises as the low half ends and falls as the high half ends.
            ph_q  <= '0;
            hi_q  <= ~hi_q;
            sck_q <= ~hi_q;
            if (hi_q) bit_q <= bit_q + 1'b1;
        end else begin
            ph_q <= ph_q + 1'b1;
        end
    end

endmodule

// File: rtl/adc_pulsar_array_if.sv
// NUM_CH-wide AD7685 reader on shared CNV/SCK; VALID 1+CONV+2*SCK_DIV*DATA_W edges after start.
// No backpressure: RESULT is held until the next VALID; ADC_OVR_FLAG_EN adds the OVR flag.
module adc_pulsar_array_if
    import adc_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 4,
    parameter int CONV_CYCLES = 128,
    parameter int ACQ_CYCLES  = 72,
    parameter int SCK_DIV     = 1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     CNV_START,
    input  logic                     FREE_RUN,
    input  logic [NUM_CH-1:0]        SDO,
    output logic                     CNV,
    output logic                     SCK,
    output logic                     SDI,
    output logic                     BUSY,
    output logic [NUM_CH*DATA_W-1:0] RESULT,
    output logic                     VALID,
    output logic                     OVR
);
    localparam int CW = cnt_w(CONV_CYCLES, ACQ_CYCLES, SCK_DIV);

    adc_state_e                state_q;
    logic [CW-1:0]             cnt_q;
    logic                      cnv_q;
    logic                      busy_q;
    logic                      valid_q;
    logic [NUM_CH*DATA_W-1:0]  shadow_q;
    logic [NUM_CH*DATA_W-1:0]  shadow_d;
    logic [NUM_CH*DATA_W-1:0]  result_q;
    logic                      sck_en;
    logic                      sample;
    logic                      rd_done;

    assign sck_en = (state_q == READ);

    adc_sck_gen #(
        .DATA_W  (DATA_W),
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk_i    (CLK),
        .rst_i    (rst),
        .en_i     (sck_en),
        .sck_o    (SCK),
        .sample_o (sample),
        .done_o   (rd_done)
    );

    always_comb begin
        shadow_d = shadow_q;
        for (int c = 0; c < NUM_CH; c++) begin
            shadow_d[c*DATA_W +: DATA_W] = {shadow_q[c*DATA_W +: DATA_W-1], SDO[c]};
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cnv_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (sample) shadow_q <= shadow_d;
            case (state_q)
                IDLE: begin
                    if (CNV_START || FREE_RUN) begin
                        state_q <= CONV;
                        cnv_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(CONV_CYCLES - 1);
                    end
                end
                CONV: begin
                    if (cnt_q == '0) begin
                        state_q <= READ;
                        cnv_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READ: begin
                    if (rd_done) begin
                        state_q  <= DONE;
                        result_q <= shadow_q;
                        valid_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ACQ_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ACQ;
                        cnt_q   <= CW'(ACQ_CYCLES - 1);
                    end
                end
                ACQ: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CNV    = cnv_q;
    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign RESULT = result_q;
    assign SDI    = 1'b1;

`ifdef ADC_OVR_FLAG_EN
    logic ovr_q;

    // A request landing on the VALID cycle must still be reported.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (CNV_START && busy_q) begin
            ovr_q <= 1'b1;
        end else if (valid_q) begin
            ovr_q <= 1'b0;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

endmodule

// File: doc/adc_pulsar_array_if.md
# adc_pulsar_array_if

Parametrised successor to the single-channel 16-bit SAR ADC reader. It drives NUM_CH AD7685-class ADCs that share one CNV and one SCK line, each on its own SDO line. Data width, conversion time, acquisition time and SCK rate are parameters. Adds a free-running mode and a held result register. It sits between the acquisition sequencer, which issues CNV_START or FREE_RUN, and the sample FIFO, which consumes RESULT on VALID.

## Interface
Parameters:
- DATA_W, 16: bits per conversion, range 8..24.
- NUM_CH, 4: number of ADCs on shared CNV/SCK, range 1..8.
- CONV_CYCLES, 128: CLK cycles CNV is held high; must be ≥1.
- ACQ_CYCLES, 72: CLK cycles of quiet acquisition after VALID; may be 0.
- SCK_DIV, 1: CLK cycles per SCK half-period; must be ≥1.

Ports:
- CLK, input, 1: sole clock.
- rst, input, 1: asynchronous, active-high reset.
- CNV_START, input, 1: single-shot request, sampled in IDLE only.
- FREE_RUN, input, 1: when high, IDLE restarts a conversion automatically.
- SDO, input, NUM_CH: serial data, bit c from ADC c.
- CNV, output, 1: convert strobe to all ADCs.
- SCK, output, 1: serial clock, idle low.
- SDI, output, 1: tied 1 (CS mode, no busy indicator).
- BUSY, output, 1: high from start acceptance until return to IDLE.
- RESULT, output, NUM_CH*DATA_W: channel c occupies [c*DATA_W +: DATA_W], MSB first.
- VALID, output, 1: one-cycle strobe; RESULT is new.
- OVR, output, 1: overrun flag (see Configuration).

## Operation
- Reset values: CNV=0, SCK=0, BUSY=0, VALID=0, OVR=0, RESULT=0, state=IDLE, all counters=0.
- IDLE:
  - If CNV_START or FREE_RUN is high, go to CONV; CNV=1, BUSY=1, counter=CONV_CYCLES-1.
  - Otherwise stay in IDLE.
- CONV:
  - Hold CNV=1.
  - When counter=0, go to READ; CNV=0, bit index=0.
  - Otherwise decrement the counter.
- READ:
  - Runs DATA_W SCK periods of 2*SCK_DIV cycles each: SCK low half first, then high half.
  - Bit b (0=MSB) of every channel is sampled into a shadow shift register on the CLK edge that ends the low half of period b.
  - MSB is therefore sampled SCK_DIV cycles after CNV falls, before any SCK edge. Bit b≥1 is sampled one low half after the falling edge of pulse b-1.
  - After the last high half, SCK=0 and go to DONE.
- DONE: copy shadow registers to RESULT; VALID=1 for exactly this cycle. Go to ACQ, or to IDLE if ACQ_CYCLES=0.
- ACQ: CNV=0, SCK=0, count ACQ_CYCLES cycles, then go to IDLE; BUSY=0.
- RESULT holds its value between VALID strobes. It is never cleared except by rst.
- CNV_START outside IDLE is ignored (no queueing).
- Dropping FREE_RUN mid-conversion finishes the current conversion; no restart follows.
- rst asserted at any point: outputs go to reset values immediately (asynchronous), and the partial shadow data is discarded.

## Timing
- VALID latency from the start-accepting edge: 1 + CONV_CYCLES + 2*SCK_DIV*DATA_W edges.
- Throughput in free-run: one sample every CONV_CYCLES + 2*SCK_DIV*DATA_W + 1 + ACQ_CYCLES + 1 cycles; the final +1 is the IDLE cycle.
- SCK is registered, glitch-free, 50% duty, and exactly DATA_W pulses per conversion.
- CNV, SCK and BUSY are driven from flops, with no combinational path from inputs.

## Configuration
- ADC_OVR_FLAG_EN defined:
  - OVR sets on any cycle where CNV_START=1 while BUSY=1.
  - OVR stays set until the next VALID strobe, where it clears. If set and clear coincide on the same cycle, set wins.
- ADC_OVR_FLAG_EN undefined: OVR tied 0, and no overrun logic is synthesised.

## Structure
- Package adc_pkg holds:
  - the state enum (IDLE, CONV, READ, DONE, ACQ);
  - a localparam function for counter width, $clog2 of max(CONV_CYCLES, ACQ_CYCLES, 2*SCK_DIV);
  - a latency function used by the bench.
- Sub-module adc_sck_gen produces:
  - SCK;
  - a sample strobe at the end of each low half;
  - a done strobe after DATA_W periods.
  - It takes an enable from the FSM.

## Test plan
- Single shot, default parameters, SCK_DIV=1, CONV_CYCLES=64; SDO model ch0=0xA5C3, ch1=0x1234, ch2=0xFFFF, ch3=0x0000 -> VALID at edge 97 after start, RESULT={0x0000,0xFFFF,0x1234,0xA5C3}, exactly 16 SCK pulses.
- FREE_RUN held high with incrementing SDO data 3 conversions -> three VALID strobes spaced 64+32+1+72+1=170 cycles, RESULT matches each pattern in order.
- SCK_DIV=3, DATA_W=18, NUM_CH=1, pattern 0x2AAAA -> SCK high and low phases each 3 cycles, 18 pulses, RESULT=0x2AAAA.
- rst pulsed during READ bit 7 -> CNV/SCK/BUSY/VALID drop immediately, RESULT=0, next CNV_START gives a clean full conversion.
- With ADC_OVR_FLAG_EN: CNV_START pulsed in CONV -> OVR=1 until the next VALID edge, then 0; second request produces no extra conversion. Without the macro -> OVR stays 0.
- ACQ_CYCLES=0 with FREE_RUN -> DONE goes straight to IDLE; period is exactly CONV_CYCLES+2*SCK_DIV*DATA_W+2.
